// File: rtl/lza_fp8_pack_pkg.sv
// Shared field positions, widths and the stage-1 register layout for the FP8 packer.
package lza_fp8_pack_pkg;

   localparam int SIGN_BIT = 7;
   localparam int EXP_MSB  = 6;
   localparam int EXP_LSB  = 3;
   localparam int FRAC_W   = 3;
   localparam int FR_W     = 9;
   localparam int EX_W     = 4;
   localparam int M_W      = 7;

   localparam logic [7:0] FP_ZERO = 8'h00;

   // The leading one of the normalized magnitude is implicit, so only the 7 bits below it are kept.
   typedef struct packed {
      logic            sign;
      logic            kill;
      logic            hi;
      logic [EX_W-1:0] ex;
      logic [M_W-1:0]  m;
   } s1_t;

endpackage

// File: rtl/lza_fp8_round.sv
// Round-to-nearest-even of the stage-1 mantissa, with fraction carry folded into the exponent.
module lza_fp8_round
   import lza_fp8_pack_pkg::*;
#(
   parameter int EXP_BIAS = 7
) (
   input  s1_t        s1,
   output logic [7:0] fp,
   output logic       inexact
);

   logic [FRAC_W-1:0] frac;
   logic              guard;
   logic              sticky;
   logic              round_up;
   logic [FRAC_W:0]   frac_r;
   logic [EX_W-1:0]   exp4;

   always_comb begin
      frac     = s1.m[6:4];
      guard    = s1.m[3];
      sticky   = |s1.m[2:0];
      round_up = guard & (sticky | frac[0]);
      frac_r   = {1'b0, frac} + {{FRAC_W{1'b0}}, round_up};
      // Evaluated in 5 bits; legal inputs always land inside the 4-bit field.
      exp4     = 4'(5'(EXP_BIAS) + 5'd7 - {1'b0, s1.ex} + {4'b0, s1.hi} + {4'b0, frac_r[FRAC_W]});

      fp      = FP_ZERO;
      inexact = 1'b0;
      if (!s1.kill) begin
         fp[SIGN_BIT]        = s1.sign;
         fp[EXP_MSB:EXP_LSB] = exp4;
         fp[FRAC_W-1:0]      = frac_r[FRAC_W-1:0];
         inexact             = guard | sticky;
      end
   end

endmodule

// File: rtl/lza_fp8_pack.sv
// Two-stage valid/ready packer: LZA fraction + shift count in, FP8 (1/4/3) with RNE out.
module lza_fp8_pack
   import lza_fp8_pack_pkg::*;
#(
   parameter int EXP_BIAS = 7,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      fr,
   input  logic [EX_W-1:0]  ex,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_fp,
   output logic             out_inexact,
   output logic             err,
   output logic [CNT_W-1:0] inexact_cnt,
   input  logic             err_clr
);

   // Handshake: a side transfers on the edge where its valid and ready are both high.
   // Stage 2 holds while out_valid & ~out_ready; stage 1 moves on when stage 2 is empty or draining.

   logic            s1_valid;
   s1_t             s1_q;
   s1_t             s1_d;
   logic            s1_adv;
   logic            in_fire;
   logic            out_fire;
   logic [FR_W-1:0] mag;
   logic            fr_zero;
   logic            fr_bad;
   logic [7:0]      fp_rnd;
   logic            inx_rnd;

   always_comb begin
      s1_adv   = s1_valid & (~out_valid | out_ready);
      in_ready = ~s1_valid | s1_adv;
      in_fire  = in_valid & in_ready;
      out_fire = out_valid & out_ready;

      mag     = fr[8] ? (~fr[FR_W-1:0] + 9'd1) : fr[FR_W-1:0];
      fr_zero = (fr == 16'h0000);
      fr_bad  = ~fr_zero & ((fr[8] == fr[7]) | (fr[15:9] != {7{fr[8]}}));

      s1_d.sign = fr[8];
      s1_d.kill = fr_zero | fr_bad;
      s1_d.hi   = mag[8];
      s1_d.ex   = ex;
      // A magnitude of exactly 256 is renormalized by one place; the exponent absorbs it via hi.
      s1_d.m    = mag[8] ? mag[7:1] : mag[6:0];
   end

   lza_fp8_round #(
      .EXP_BIAS (EXP_BIAS)
   ) u_round (
      .s1      (s1_q),
      .fp      (fp_rnd),
      .inexact (inx_rnd)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid    <= 1'b0;
         s1_q        <= '0;
         out_valid   <= 1'b0;
         out_fp      <= FP_ZERO;
         out_inexact <= 1'b0;
         err         <= 1'b0;
         inexact_cnt <= '0;
      end else begin
         if (in_fire) begin
            s1_valid <= 1'b1;
            s1_q     <= s1_d;
         end else if (s1_adv) begin
            s1_valid <= 1'b0;
         end

         if (s1_adv) begin
            out_valid   <= 1'b1;
            out_fp      <= fp_rnd;
            out_inexact <= inx_rnd;
         end else if (out_fire) begin
            out_valid <= 1'b0;
         end

         // A malformed capture wins over a simultaneous clear.
         if (in_fire && fr_bad) begin
            err <= 1'b1;
         end else if (err_clr) begin
            err <= 1'b0;
         end

         if (err_clr) begin
            inexact_cnt <= (out_fire && out_inexact) ? CNT_W'(1) : '0;
         end else if (out_fire && out_inexact && (inexact_cnt != {CNT_W{1'b1}})) begin
            inexact_cnt <= inexact_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_lza_fp8_pack.sv
// Bench for lza_fp8_pack: directed literal cases, backpressure and reset, then randomized traffic vs a value model.
module tb_lza_fp8_pack;

   localparam int EXP_BIAS = 7;
   localparam int CNT_W    = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [15:0]      fr;
   logic [3:0]       ex;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_fp;
   logic             out_inexact;
   logic             err;
   logic [CNT_W-1:0] inexact_cnt;
   logic             err_clr;

   int               n_checks = 0;
   int               n_pass   = 0;
   int               n_deliv  = 0;
   logic [8:0]       exp_q[$];
   logic             err_m;
   logic [CNT_W-1:0] cnt_m;
   logic             fire_in;
   logic             xfer_inx;

   lza_fp8_pack #(
      .EXP_BIAS (EXP_BIAS),
      .CNT_W    (CNT_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .fr          (fr),
      .ex          (ex),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_fp      (out_fp),
      .out_inexact (out_inexact),
      .err         (err),
      .inexact_cnt (inexact_cnt),
      .err_clr     (err_clr)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, want);
   endtask

   function automatic logic is_malformed(input logic [15:0] f);
      int v;
      v = int'($signed(f));
      return (f != 16'h0) && !((v >= 128 && v <= 255) || (v >= -256 && v <= -129));
   endfunction

   // Value model: {inexact, fp} from the real magnitude and its power-of-two range.
   function automatic logic [8:0] model(input logic [15:0] f, input logic [3:0] e);
      int   v, mag, k, q, rem, half, bexp;
      logic s;
      if (f == 16'h0 || is_malformed(f)) return 9'h000;
      v    = int'($signed(f));
      s    = (v < 0);
      mag  = s ? -v : v;
      k    = (mag >= 256) ? 8 : 7;
      q    = mag >> (k - 3);
      rem  = mag - (q << (k - 3));
      half = 1 << (k - 4);
      if (rem > half || (rem == half && (q % 2) == 1)) q++;
      if (q == 16) begin
         q = 8;
         k++;
      end
      bexp = EXP_BIAS + k - int'(e);
      return {(rem != 0), s, bexp[3:0], q[2:0]};
   endfunction

   // Scoreboard/compare process: checks outputs and predicts the next edge's effects.
   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         err_m   = 1'b0;
         cnt_m   = '0;
         fire_in = 1'b0;
      end else begin
         xfer_inx = 1'b0;
         check("err", err, err_m);
         check("inexact_cnt", inexact_cnt, cnt_m);
         check("in_ready", in_ready, !(exp_q.size() == 2 && !out_ready));
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL spurious_out: got out_valid=1 with fp %0h expected no item", out_fp);
            end else begin
               check("out_fp", out_fp, exp_q[0][7:0]);
               check("out_inexact", out_inexact, exp_q[0][8]);
               if (out_ready) begin
                  xfer_inx = exp_q[0][8];
                  void'(exp_q.pop_front());
                  n_deliv++;
               end
            end
         end
         if (err_clr) cnt_m = xfer_inx ? CNT_W'(1) : '0;
         else if (xfer_inx && cnt_m != {CNT_W{1'b1}}) cnt_m = cnt_m + CNT_W'(1);
         fire_in = in_valid && in_ready;
         if (fire_in && is_malformed(fr)) err_m = 1'b1;
         else if (err_clr) err_m = 1'b0;
         if (fire_in) exp_q.push_back(model(fr, ex));
      end
   end

   task automatic directed(input string name, input logic [15:0] f, input logic [3:0] e,
                           input logic [7:0] want_fp, input logic want_inx);
      int n;
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      fr        = f;
      ex        = e;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 8);
      check({name, "_latency"}, n, 2);
      check({name, "_fp"}, out_fp, want_fp);
      check({name, "_inexact"}, out_inexact, want_inx);
   endtask

   task automatic rand_item(output logic [15:0] f, output logic [3:0] e);
      int sel, v;
      sel = $urandom_range(0, 9);
      e   = 4'($urandom_range(0, 8));
      if (sel == 0) begin
         f = 16'h0;
         e = 4'($urandom_range(0, 15));
      end else if (sel == 1) begin
         f = 16'($urandom);
      end else if (sel == 2) begin
         f = 16'hFF00;
      end else if ($urandom_range(0, 1) == 1) begin
         v = $urandom_range(129, 256);
         f = 16'(-v);
      end else begin
         v = $urandom_range(128, 255);
         f = 16'(v);
      end
   endtask

   logic [15:0] bp_fr[3] = '{16'h0090, 16'hFF40, 16'h00C4};
   logic [3:0]  bp_ex[3] = '{4'd7, 4'd5, 4'd3};

   initial begin
      int  n_acc;
      int  d0;
      logic acc;
      logic [15:0] rf;
      logic [3:0]  re;

      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      err_clr   = 1'b0;
      fr        = 16'h0;
      ex        = 4'h0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_fp", out_fp, 8'h00);
      check("rst_out_inexact", out_inexact, 0);
      check("rst_err", err, 0);
      check("rst_cnt", inexact_cnt, 0);

      directed("exact",     16'h0080, 4'd7, 8'h38, 1'b0);
      directed("neg256",    16'hFF00, 4'd8, 8'hB8, 1'b0);
      directed("carry",     16'h00FF, 4'd0, 8'h78, 1'b1);
      @(posedge clk); #1;
      check("cnt_after_carry", inexact_cnt, 1);
      directed("tie_up",    16'h0098, 4'd7, 8'h3A, 1'b1);
      directed("tie_even",  16'h0088, 4'd7, 8'h38, 1'b1);
      directed("zero",      16'h0000, 4'hF, 8'h00, 1'b0);
      check("zero_err", err, 0);
      directed("malformed", 16'h0040, 4'd7, 8'h00, 1'b0);
      check("malformed_err", err, 1);
      @(posedge clk); #1 err_clr = 1'b1;
      @(posedge clk); #1 err_clr = 1'b0;
      check("clr_err", err, 0);
      check("clr_cnt", inexact_cnt, 0);

      // Backpressure: three back-to-back offers against a stalled consumer.
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      fr        = bp_fr[0];
      ex        = bp_ex[0];
      n_acc     = 0;
      d0        = n_deliv;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         if (acc) begin
            n_acc++;
            if (n_acc < 3) begin
               fr = bp_fr[n_acc];
               ex = bp_ex[n_acc];
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      @(negedge clk);
      check("bp_accepts", n_acc, 2);
      check("bp_in_ready_low", in_ready, 0);
      @(posedge clk); #1 out_ready = 1'b1;
      for (int c = 0; c < 10 && n_acc < 3; c++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         if (acc) begin
            n_acc++;
            in_valid = 1'b0;
         end
      end
      for (int c = 0; c < 10 && exp_q.size() != 0; c++) @(negedge clk);
      check("bp_all_accepted", n_acc, 3);
      check("bp_drained", exp_q.size(), 0);
      check("bp_delivered", n_deliv - d0, 3);

      // Reset while both stages are full and stalled.
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      fr        = 16'h00A0;
      ex        = 4'd6;
      @(posedge clk); #1;
      fr = 16'hFF7F;
      ex = 4'd2;
      @(posedge clk); #1 in_valid = 1'b0;
      @(posedge clk); #1;
      check("stall_out_valid", out_valid, 1);
      reset = 1'b1;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 1);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("post_rst_out_valid", out_valid, 0);

      // Random traffic with occasional clears.
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         if (!in_valid || fire_in) begin
            in_valid = ($urandom_range(0, 3) != 0);
            rand_item(rf, re);
            fr = rf;
            ex = re;
         end
         out_ready = ($urandom_range(0, 3) != 0);
         err_clr   = ($urandom_range(0, 63) == 0);
      end
      // Long run without clears so the counter reaches saturation.
      for (int c = 0; c < 1500; c++) begin
         @(posedge clk); #1;
         if (!in_valid || fire_in) begin
            in_valid = 1'b1;
            rand_item(rf, re);
            fr = rf;
            ex = re;
         end
         out_ready = ($urandom_range(0, 7) != 0);
         err_clr   = 1'b0;
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 10 && exp_q.size() != 0; c++) @(negedge clk);
      check("final_drained", exp_q.size(), 0);
      check("cnt_saturated", inexact_cnt, {CNT_W{1'b1}});
      @(posedge clk); #1 err_clr = 1'b1;
      @(posedge clk); #1 err_clr = 1'b0;
      check("final_clr_cnt", inexact_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
